// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI data-bus arbiter: master-index type
// and the rotating-priority search used to pick the next address-phase winner.
package obi_arb_pkg;

    // Upper bound on the number of masters the search helper handles.
    localparam int unsigned MAX_MASTERS = 16;
    localparam int unsigned MAX_IDX_W   = 4;

    typedef logic [MAX_IDX_W-1:0] master_idx_t;

    // Width of a master index for n masters; a single master still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First asserted request found when scanning n masters starting at 'start'
    // and wrapping around. With start fixed at 0 this is lowest-index-wins.
    function automatic master_idx_t rr_search(input logic [MAX_MASTERS-1:0] req,
                                              input master_idx_t           start,
                                              input int unsigned           n);
        master_idx_t win;
        logic        found;
        logic [31:0] j;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            j = (32'(start) + i) % n;
            if ((i < n) && !found && req[j[MAX_IDX_W-1:0]]) begin
                found = 1'b1;
                win   = j[MAX_IDX_W-1:0];
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Synchronous FIFO of master indices: one entry per granted-but-unanswered
// transaction, so responses can be routed back in issue order.
module obi_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_idx,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage: written on push, never reset (contents only valid below count).
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_idx;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_data_arbiter.sv
// N-master to 1-slave OBI data-bus arbiter. Address phase is arbitrated and
// held stable until grant; issuer indices are queued so each response goes
// back to its master. Define OBI_ARB_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise fixed priority (lowest index wins).
module obi_data_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_MASTERS-1:0]              m_req_i,
    output logic [NUM_MASTERS-1:0]              m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0]              m_rvalid_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata_o,
    output logic [NUM_MASTERS-1:0]              m_err_o,
    output logic                                s_req_o,
    input  logic                                s_gnt_i,
    output logic [ADDR_WIDTH-1:0]               s_addr_o,
    output logic                                s_we_o,
    output logic [DATA_WIDTH/8-1:0]             s_be_o,
    output logic [DATA_WIDTH-1:0]               s_wdata_o,
    input  logic                                s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]               s_rdata_i,
    input  logic                                s_err_i,
    output logic                                spurious_rsp_o
);
    localparam int IDX_W = idx_width(NUM_MASTERS);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [DATA_WIDTH-1:0] wdata;
    } addr_phase_t;

    logic        lock_q;
    idx_t        lock_idx_q;
    idx_t        arb_idx;
    idx_t        winner;
    idx_t        sel;
    addr_phase_t sel_phase;
    logic        handshake;
    logic        pop;
    logic        spurious_q;
    logic        fifo_full;
    logic        fifo_empty;
    idx_t        fifo_head;
    logic [CNT_W-1:0] fifo_count;

`ifdef OBI_ARB_ROUND_ROBIN_EN
    idx_t rr_ptr_q;

    assign arb_idx = idx_t'(rr_search(MAX_MASTERS'(m_req_i), master_idx_t'(rr_ptr_q), NUM_MASTERS));

    // Rotate priority past the master that just completed its address phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (handshake) begin
            rr_ptr_q <= (winner == idx_t'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
        end
    end
`else
    assign arb_idx = idx_t'(rr_search(MAX_MASTERS'(m_req_i), '0, NUM_MASTERS));
`endif

    // Pick the winner: a stalled request keeps its master until granted.
    // During reset the address mux points at master 0.
    always_comb begin
        winner          = lock_q ? lock_idx_q : arb_idx;
        sel             = rst_i ? '0 : winner;
        sel_phase.addr  = m_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
        sel_phase.we    = m_we_i[sel];
        sel_phase.be    = m_be_i[sel*BE_W +: BE_W];
        sel_phase.wdata = m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    end

    assign s_addr_o  = sel_phase.addr;
    assign s_we_o    = sel_phase.we;
    assign s_be_o    = sel_phase.be;
    assign s_wdata_o = sel_phase.wdata;

    // A full ID FIFO blocks new requests even if a response frees a slot this cycle.
    assign s_req_o   = ~rst_i & ~fifo_full & m_req_i[winner];
    assign handshake = s_req_o & s_gnt_i;
    assign m_gnt_o   = handshake ? (NUM_MASTERS'(1) << winner) : '0;

    // Responses return in order to the issuer at the FIFO head.
    assign pop        = ~rst_i & s_rvalid_i & ~fifo_empty;
    assign m_rvalid_o = pop ? (NUM_MASTERS'(1) << fifo_head) : '0;
    assign m_err_o    = (pop & s_err_i) ? (NUM_MASTERS'(1) << fifo_head) : '0;
    assign m_rdata_o  = {NUM_MASTERS{s_rdata_i}};

    assign spurious_rsp_o = spurious_q;

    // Address-phase lock: capture the winner while the slave withholds grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (s_req_o) begin
            lock_q     <= ~s_gnt_i;
            lock_idx_q <= winner;
        end
    end

    // Flag a response that arrived with nothing outstanding, one cycle later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= s_rvalid_i & (fifo_count == '0);
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IDX_W)
    ) u_id_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (handshake),
        .push_idx (winner),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
